matrix_scratchpad: RTL and testbench

- Single-port on-chip word memory that serves the Matrix_Multiplication engine's memory bus (mem_operation / addr_o / data_o / data_i / mem_opdone) as its direct downstream consumer.
- Also exposes a host port so the CPU side can load the parameter words (0..3) and matrices A and B, and read back matrix C.
- Arbitrates the two ports onto one RAM with a fixed, parameterised access latency.

---
 rtl/matrix_scratchpad.sv | 171 +++++++++++++++++
 tb/tb_matrix_scratchpad.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scratchpad.sv
// ---------------------------------------------------------------------------
// matrix_scratchpad
//
// Single-port word memory shared by two requesters:
//   * the matrix-multiply engine (mem_operation style bus), and
//   * a host port used to load parameters and operands and read results.
// One transaction is in flight at a time. Each one spends ACC_LAT cycles in
// ACCESS and one cycle in RESP, where the granted port gets its ack pulse.
// Ties in IDLE alternate between the ports. rr_last follows the most recent
// winner, so the engine wins the first tie after reset.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   reset_n    : asynchronous active-low reset
//   acc_op     : engine op, 01 read, 11 write, 00/10 idle
//   acc_addr   : engine word address
//   acc_wdata  : engine write data
//   acc_rdata  : engine read data, held until the next engine read completes
//   acc_opdone : one-cycle engine completion pulse
//   host_req   : host request, held high until host_ack
//   host_we    : host direction, 1 write / 0 read
//   host_addr  : host word address
//   host_wdata : host write data
//   host_rdata : host read data, held until the next host read completes
//   host_ack   : one-cycle host completion pulse
//   busy       : high whenever a transaction is in progress
//   err_oob    : sticky flag, set by any access with addr >= DEPTH
// ---------------------------------------------------------------------------
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module matrix_scratchpad #(
    parameter int DATA_W  = `TYPE_BW,
    parameter int DEPTH   = 1024,
    parameter int ACC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        acc_op,
    input  logic [31:0]       acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_opdone,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              busy,
    output logic              err_oob
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 2;   // counts ACC_LAT-1 down to 0, ACC_LAT <= 4

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_reg, state_next;
    logic                port_reg;      // 1: engine owns the transaction
    logic                we_reg;
    logic [31:0]         addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [CW-1:0]       cnt_reg;
    logic                rr_last_reg;   // 1: engine won the latest grant
    logic [DATA_W-1:0]   acc_rdata_reg;
    logic [DATA_W-1:0]   host_rdata_reg;
    logic                err_oob_reg;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                eng_req;
    logic                grant;
    logic                grant_eng;
    logic                in_range;
    logic                do_access;
    logic [AW-1:0]       idx;

    // acc_op[0] separates 01/11 (requests) from 00/10 (idle).
    assign eng_req   = acc_op[0];
    assign in_range  = (addr_reg < 32'(DEPTH));
    assign idx       = addr_reg[AW-1:0];
    assign do_access = (state_reg == ACCESS) && (cnt_reg == '0);

    always_comb begin
        grant     = (state_reg == IDLE) && (eng_req || host_req);
        grant_eng = eng_req;
        if (eng_req && host_req) begin
            grant_eng = !rr_last_reg;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (cnt_reg == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_reg != IDLE);
        acc_opdone = (state_reg == RESP) &&  port_reg;
        host_ack   = (state_reg == RESP) && !port_reg;
        acc_rdata  = acc_rdata_reg;
        host_rdata = host_rdata_reg;
        err_oob    = err_oob_reg;
    end

    // Request latching, latency counter, read data and error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_reg       <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            rr_last_reg    <= 1'b0;
            acc_rdata_reg  <= '0;
            host_rdata_reg <= '0;
            err_oob_reg    <= 1'b0;
        end else begin
            if (grant) begin
                port_reg    <= grant_eng;
                rr_last_reg <= grant_eng;
                we_reg      <= grant_eng ? acc_op[1]  : host_we;
                addr_reg    <= grant_eng ? acc_addr   : host_addr;
                wdata_reg   <= grant_eng ? acc_wdata  : host_wdata;
                cnt_reg     <= CW'(ACC_LAT - 1);
            end else if ((state_reg == ACCESS) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CW'(1);
            end

            if (do_access) begin
                if (!in_range) begin
                    err_oob_reg <= 1'b1;
                end
                if (!we_reg) begin
                    if (port_reg) begin
                        acc_rdata_reg  <= in_range ? mem[idx] : '0;
                    end else begin
                        host_rdata_reg <= in_range ? mem[idx] : '0;
                    end
                end
            end
        end
    end

    // RAM write port. Reset forces IDLE asynchronously, so an aborted
    // transaction never reaches do_access.
    always_ff @(posedge clk) begin
        if (do_access && we_reg && in_range) begin
            mem[idx] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_matrix_scratchpad.sv
// ---------------------------------------------------------------------------
// tb_matrix_scratchpad
//
// Two scratchpads: instance 0 with ACC_LAT=1 and instance 1 with ACC_LAT=4.
// A transaction-level model tracks the following for each instance:
//   * the memory contents,
//   * the grant schedule, where a grant occupies the port for LAT+2 cycles,
//   * the alternating tie break,
//   * the expected read data.
// It checks every output on every cycle outside reset. Directed sequences
// add literal checks on latency and data.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_matrix_scratchpad;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [1:0]  acc_op     [2];
    logic [31:0] acc_addr   [2];
    logic [31:0] acc_wdata  [2];
    logic [31:0] acc_rdata  [2];
    logic        acc_opdone [2];
    logic        host_req   [2];
    logic        host_we    [2];
    logic [31:0] host_addr  [2];
    logic [31:0] host_wdata [2];
    logic [31:0] host_rdata [2];
    logic        host_ack   [2];
    logic        busy       [2];
    logic        err_oob    [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        matrix_scratchpad #(
            .DATA_W (32),
            .DEPTH  (1024),
            .ACC_LAT(gi == 0 ? 1 : 4)
        ) u_dut (
            .clk       (clk),
            .reset_n   (rst_n),
            .acc_op    (acc_op[gi]),
            .acc_addr  (acc_addr[gi]),
            .acc_wdata (acc_wdata[gi]),
            .acc_rdata (acc_rdata[gi]),
            .acc_opdone(acc_opdone[gi]),
            .host_req  (host_req[gi]),
            .host_we   (host_we[gi]),
            .host_addr (host_addr[gi]),
            .host_wdata(host_wdata[gi]),
            .host_rdata(host_rdata[gi]),
            .host_ack  (host_ack[gi]),
            .busy      (busy[gi]),
            .err_oob   (err_oob[gi])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // ---------------- transaction-level model ----------------
    bit          vt      [2];   // a transaction has been granted since reset
    int          gcyc    [2];   // cycle index of the grant edge
    int          free_at [2];   // first edge at which a new grant may occur
    bit          gport   [2];   // 1: engine
    bit          gwe     [2];
    logic [31:0] gaddr   [2];
    logic [31:0] gdata   [2];
    bit          rr_eng  [2];
    logic [31:0] mm      [2][1024];
    bit          wrn     [2][1024];
    logic [31:0] e_ard   [2];
    logic [31:0] e_hrd   [2];
    bit          e_ak    [2];   // expected engine rdata is known
    bit          e_hk    [2];
    bit          e_oob   [2];

    task automatic model_access(input int k);
        logic [31:0] d;
        bit          inr;
        bit          known;
        inr = (gaddr[k] < 32'd1024);
        if (!inr) e_oob[k] = 1'b1;
        if (gwe[k]) begin
            if (inr) begin
                mm[k][gaddr[k][9:0]]  = gdata[k];
                wrn[k][gaddr[k][9:0]] = 1'b1;
            end
        end else begin
            d     = inr ? mm[k][gaddr[k][9:0]] : 32'd0;
            known = !inr || wrn[k][gaddr[k][9:0]];
            if (gport[k]) begin e_ard[k] = d; e_ak[k] = known; end
            else          begin e_hrd[k] = d; e_hk[k] = known; end
        end
    endtask

    initial begin
        bit e, h;
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    vt[k] = 0; free_at[k] = 0; rr_eng[k] = 0;
                    e_ard[k] = 0; e_hrd[k] = 0; e_ak[k] = 1; e_hk[k] = 1;
                    e_oob[k] = 0;
                end else begin
                    if (vt[k] && cyc == gcyc[k] + lat(k)) model_access(k);
                    if (cyc >= free_at[k]) begin
                        e = (acc_op[k] == 2'b01) || (acc_op[k] == 2'b11);
                        h = host_req[k];
                        if (e || h) begin
                            gport[k]   = (e && h) ? !rr_eng[k] : e;
                            rr_eng[k]  = gport[k];
                            gwe[k]     = gport[k] ? (acc_op[k] == 2'b11) : host_we[k];
                            gaddr[k]   = gport[k] ? acc_addr[k]  : host_addr[k];
                            gdata[k]   = gport[k] ? acc_wdata[k] : host_wdata[k];
                            vt[k]      = 1;
                            gcyc[k]    = cyc;
                            free_at[k] = cyc + lat(k) + 2;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        bit in_txn, resp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    in_txn = vt[k] && cyc >= gcyc[k] && cyc <= gcyc[k] + lat(k);
                    resp   = vt[k] && cyc == gcyc[k] + lat(k);
                    chk($sformatf("i%0d busy", k),       32'(busy[k]),       32'(in_txn));
                    chk($sformatf("i%0d acc_opdone", k), 32'(acc_opdone[k]), 32'(resp && gport[k]));
                    chk($sformatf("i%0d host_ack", k),   32'(host_ack[k]),   32'(resp && !gport[k]));
                    chk($sformatf("i%0d err_oob", k),    32'(err_oob[k]),    32'(e_oob[k]));
                    if (e_ak[k]) chk($sformatf("i%0d acc_rdata", k),  acc_rdata[k],  e_ard[k]);
                    if (e_hk[k]) chk($sformatf("i%0d host_rdata", k), host_rdata[k], e_hrd[k]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Both drivers are called at a falling edge and return at the falling
    // edge of the ack cycle. n counts cycles from request to ack.
    task automatic host_xfer(input int k, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output int n);
        host_we[k] = we; host_addr[k] = addr; host_wdata[k] = wd; host_req[k] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!host_ack[k] && n < 40);
        chk($sformatf("i%0d host_ack_seen", k), 32'(host_ack[k]), 32'd1);
        rd = host_rdata[k];
        host_req[k] = 1'b0;
        $display("i%0d host %s addr=%0d wdata=%h rdata=%h lat=%0d",
                 k, we ? "wr" : "rd", addr, wd, rd, n);
    endtask

    task automatic acc_xfer(input int k, input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input bit keep,
                            output logic [31:0] rd, output int n);
        acc_op[k] = op; acc_addr[k] = addr; acc_wdata[k] = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!acc_opdone[k] && n < 40);
        chk($sformatf("i%0d acc_opdone_seen", k), 32'(acc_opdone[k]), 32'd1);
        rd = acc_rdata[k];
        if (!keep) acc_op[k] = 2'b00;
        $display("i%0d eng  %s addr=%0d wdata=%h rdata=%h lat=%0d",
                 k, (op == 2'b11) ? "wr" : "rd", addr, wd, rd, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd, rdh, a_v [4], b_v [4], c_v [4];
        int          n, nh;
        logic [31:0] c_exp [4];

        for (int k = 0; k < 2; k++) begin
            acc_op[k] = 2'b00; acc_addr[k] = 0; acc_wdata[k] = 0;
            host_req[k] = 0; host_we[k] = 0; host_addr[k] = 0; host_wdata[k] = 0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset aborts an in-flight host write
        host_xfer(0, 1, 5, 32'h11, rd, n);
        @(negedge clk);
        host_we[0] = 1; host_addr[0] = 5; host_wdata[0] = 32'hAB; host_req[0] = 1;
        @(negedge clk);
        chk("busy_mid_access", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0; host_req[0] = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy[0]), 32'd0);
            chk("rst_err_oob", 32'(err_oob[0]), 32'd0);
            chk("rst_host_ack", 32'(host_ack[0]), 32'd0);
            chk("rst_host_rdata", host_rdata[0], 32'd0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Tie after reset goes to the engine, then alternates back
        for (int t = 0; t < 2; t++) begin
            fork
                acc_xfer(0, 2'b01, 4, 0, 0, rd, n);
                host_xfer(0, 0, 8, 0, rdh, nh);
            join
            chk($sformatf("tie%0d_eng_lat", t), 32'(n), 32'd2);
            chk($sformatf("tie%0d_host_lat", t), 32'(nh), 32'd5);
            @(negedge clk);
        end

        host_xfer(0, 0, 5, 0, rd, n);
        chk("addr5_after_reset", rd, 32'h11);

        // Host load of params, A and B
        for (int i = 0; i < 4; i++) host_xfer(0, 1, i, 2, rd, n);
        for (int i = 0; i < 4; i++) host_xfer(0, 1, 4 + i, i + 1, rd, n);
        for (int i = 0; i < 4; i++) host_xfer(0, 1, 8 + i, i + 5, rd, n);

        // acc_op=10 is not a request
        acc_op[0] = 2'b10;
        repeat (4) @(negedge clk);
        chk("op10_ignored", 32'(busy[0]), 32'd0);
        acc_op[0] = 2'b00;

        // FETCH_PARAMS pattern: op held at 01, address stepped at each opdone
        for (int i = 0; i < 5; i++) begin
            acc_xfer(0, 2'b01, i, 0, i < 4, rd, n);
            chk($sformatf("fetch%0d_data", i), rd, (i < 4) ? 32'd2 : 32'd1);
            chk($sformatf("fetch%0d_lat", i), 32'(n), (i == 0) ? 32'd2 : 32'd3);
        end

        // Engine-side 2x2 multiply
        for (int i = 0; i < 8; i++) begin
            acc_xfer(0, 2'b01, 4 + i, 0, i < 7, rd, n);
            if (i < 4) a_v[i] = rd; else b_v[i - 4] = rd;
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                c_v[r*2 + c] = a_v[r*2] * b_v[c] + a_v[r*2 + 1] * b_v[2 + c];
        for (int i = 0; i < 4; i++) acc_xfer(0, 2'b11, 12 + i, c_v[i], i < 3, rd, n);
        c_exp[0] = 19; c_exp[1] = 22; c_exp[2] = 43; c_exp[3] = 50;
        for (int i = 0; i < 4; i++) begin
            host_xfer(0, 0, 12 + i, 0, rd, n);
            chk($sformatf("c%0d", i), rd, c_exp[i]);
        end

        // Out-of-range accesses
        @(negedge clk);
        host_xfer(0, 1, 1024, 32'h55, rd, n);
        chk("oob_wr_lat", 32'(n), 32'd2);
        chk("oob_flag", 32'(err_oob[0]), 32'd1);
        host_xfer(0, 0, 0, 0, rd, n);
        chk("addr0_unchanged", rd, 32'd2);
        acc_xfer(0, 2'b01, 2000, 0, 0, rd, n);
        chk("oob_rd_zero", rd, 32'd0);
        chk("oob_sticky", 32'(err_oob[0]), 32'd1);

        // ACC_LAT=4 instance
        acc_xfer(1, 2'b11, 20, 32'h1234, 0, rd, n);
        chk("lat4_wr_lat", 32'(n), 32'd5);
        @(negedge clk);
        host_xfer(1, 0, 20, 0, rd, n);
        chk("lat4_rd_lat", 32'(n), 32'd5);
        chk("lat4_rd_data", rd, 32'h1234);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
